led_scan: RTL and testbench

LED_SCAN -- requirements
Module: led_scan

---
 rtl/led_scan.sv | 202 ++++++++++++++++++++
 tb/tb_led_scan.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/led_scan.sv
// -----------------------------------------------------------------------------
// led_scan -- four-digit multiplexed seven-segment display driver
//
// Scans four hex digits onto a common-anode display. Each digit owns a slot of
// 2^DIV_WIDTH gclk cycles. The first DEAD cycles of every slot keep all anodes
// off so that segment changes cannot ghost onto the neighbouring digit.
// New digit values are written into a pending register at any time. They are
// copied into the display register only at a frame boundary, so one frame
// never mixes old and new values.
//
// Parameters
//   DIV_WIDTH  prescaler width; slot length = 2^DIV_WIDTH cycles (3..24)
//   DEAD       anode-off cycles at the start of each slot (0..2^DIV_WIDTH-1)
//
// Ports
//   gclk     in   1   clock; all state changes on its rising edge
//   rst      in   1   synchronous reset, active low
//   data     in  16   four hex digits, digit k = data[4k+3:4k]
//   dp       in   4   decimal point per digit, 1 = lit
//   blank    in   4   per-digit blank, 1 = digit dark (dp included)
//   data_we  in   1   write strobe; captures data/dp/blank this cycle
//   frame    out  1   one-cycle pulse in the cycle after each frame boundary
//   led      out 12   [11:8] anodes digit3..0, [7:0] {dp,g..a}; all active low
// -----------------------------------------------------------------------------
module led_scan #(
    parameter int DIV_WIDTH = 16,
    parameter int DEAD      = 4
) (
    input  logic        gclk,
    input  logic        rst,
    input  logic [15:0] data,
    input  logic [3:0]  dp,
    input  logic [3:0]  blank,
    input  logic        data_we,
    output logic        frame,
    output logic [11:0] led
);

    // -------------------------------------------------------------------------
    // Elaboration-time parameter guards
    // -------------------------------------------------------------------------
    if (DIV_WIDTH < 3 || DIV_WIDTH > 24) begin : g_bad_div_width
        $error("led_scan: DIV_WIDTH must be in 3..24");
    end

    if (DEAD < 0 || DEAD > ((1 << DIV_WIDTH) - 1)) begin : g_bad_dead
        $error("led_scan: DEAD must be in 0..2^DIV_WIDTH-1");
    end

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [DIV_WIDTH-1:0] r_cnt;
    logic [1:0]           r_idx;
    logic                 r_frame;
    logic [11:0]          r_led;

    logic [15:0]          r_pend_data;
    logic [3:0]           r_pend_dp;
    logic [3:0]           r_pend_blank;

    logic [15:0]          r_disp_data;
    logic [3:0]           r_disp_dp;
    logic [3:0]           r_disp_blank;

    // -------------------------------------------------------------------------
    // Combinational helpers
    // -------------------------------------------------------------------------
    logic                 w_tick;
    logic                 w_boundary;
    logic                 w_dead;
    logic [3:0]           w_anode_n;
    logic [3:0]           w_nib_arr [4];
    logic [3:0]           w_nib;
    logic                 w_dp_sel;
    logic                 w_blank_sel;
    logic [6:0]           w_seg;
    logic [11:0]          w_led_next;

    // The prescaler wraps by natural overflow; tick marks the last slot cycle.
    assign w_tick     = &r_cnt;
    assign w_boundary = w_tick && (r_idx == 2'd3);

    // Dead-time window at the start of each slot. With DEAD = 0 the window is
    // empty and the comparison is removed entirely.
    if (DEAD == 0) begin : g_no_dead
        assign w_dead = 1'b0;
    end else begin : g_dead
        localparam logic [DIV_WIDTH-1:0] DEAD_CNT = DIV_WIDTH'(DEAD);
        assign w_dead = (r_cnt < DEAD_CNT);
    end

    // One anode per digit: low only when this digit is being scanned and the
    // slot is past its dead time.
    for (genvar gi = 0; gi < 4; gi++) begin : g_digit
        assign w_anode_n[gi] = w_dead || (r_idx != 2'(gi));
        assign w_nib_arr[gi] = r_disp_data[4*gi +: 4];
    end

    assign w_nib       = w_nib_arr[r_idx];
    assign w_dp_sel    = r_disp_dp[r_idx];
    assign w_blank_sel = r_disp_blank[r_idx];

    // Hex to active-high gfedcba
    always_comb begin
        w_seg = 7'h00;
        case (w_nib)
            4'h0:    w_seg = 7'h3F;
            4'h1:    w_seg = 7'h06;
            4'h2:    w_seg = 7'h5B;
            4'h3:    w_seg = 7'h4F;
            4'h4:    w_seg = 7'h66;
            4'h5:    w_seg = 7'h6D;
            4'h6:    w_seg = 7'h7D;
            4'h7:    w_seg = 7'h07;
            4'h8:    w_seg = 7'h7F;
            4'h9:    w_seg = 7'h6F;
            4'hA:    w_seg = 7'h77;
            4'hB:    w_seg = 7'h7C;
            4'hC:    w_seg = 7'h39;
            4'hD:    w_seg = 7'h5E;
            4'hE:    w_seg = 7'h79;
            default: w_seg = 7'h71;
        endcase
    end

    // Blanking darkens segments and dp but leaves the anode timing alone, so
    // the per-digit duty cycle stays identical whether a digit is lit or not.
    always_comb begin
        w_led_next = {w_anode_n, 8'hFF};
        if (!w_blank_sel) begin
            w_led_next[7:0] = {~w_dp_sel, ~w_seg};
        end
    end

    // -------------------------------------------------------------------------
    // Scan counters and frame pulse
    // -------------------------------------------------------------------------
    always_ff @(posedge gclk) begin
        if (!rst) begin
            r_cnt   <= '0;
            r_idx   <= 2'd0;
            r_frame <= 1'b0;
        end else begin
            r_cnt   <= r_cnt + 1'b1;
            r_frame <= w_boundary;
            if (w_tick) begin
                r_idx <= r_idx + 2'd1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Pending / display registers
    // -------------------------------------------------------------------------
    always_ff @(posedge gclk) begin
        if (!rst) begin
            r_pend_data  <= 16'h0000;
            r_pend_dp    <= 4'h0;
            r_pend_blank <= 4'h0;
        end else if (data_we) begin
            r_pend_data  <= data;
            r_pend_dp    <= dp;
            r_pend_blank <= blank;
        end
    end

    // A write landing in the boundary cycle bypasses pending, otherwise it
    // would be parked for a whole extra frame behind a stale value.
    always_ff @(posedge gclk) begin
        if (!rst) begin
            r_disp_data  <= 16'h0000;
            r_disp_dp    <= 4'h0;
            r_disp_blank <= 4'h0;
        end else if (w_boundary) begin
            if (data_we) begin
                r_disp_data  <= data;
                r_disp_dp    <= dp;
                r_disp_blank <= blank;
            end else begin
                r_disp_data  <= r_pend_data;
                r_disp_dp    <= r_pend_dp;
                r_disp_blank <= r_pend_blank;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Registered pin drive
    // -------------------------------------------------------------------------
    always_ff @(posedge gclk) begin
        if (!rst) begin
            r_led <= 12'hFFF;
        end else begin
            r_led <= w_led_next;
        end
    end

    assign frame = r_frame;
    assign led   = r_led;

endmodule

// File: tb/tb_led_scan.sv
// -----------------------------------------------------------------------------
// tb_led_scan -- bench for led_scan with DIV_WIDTH=4 (16-cycle slots,
// 64-cycle frames) and DEAD=4.
// The stimulus process writes digits and pushes the hand-computed led pattern
// of the frame that must follow into a queue. The monitor pops one entry at
// every frame pulse and checks dead-time and live samples of all four slots.
// -----------------------------------------------------------------------------
module tb_led_scan;

    logic        gclk;
    logic        rst;
    logic [15:0] data;
    logic [3:0]  dp;
    logic [3:0]  blank;
    logic        data_we;
    logic        frame;
    logic [11:0] led;

    led_scan #(
        .DIV_WIDTH (4),
        .DEAD      (4)
    ) dut (
        .gclk    (gclk),
        .rst     (rst),
        .data    (data),
        .dp      (dp),
        .blank   (blank),
        .data_we (data_we),
        .frame   (frame),
        .led     (led)
    );

    initial gclk = 1'b0;
    always #5 gclk = ~gclk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Expected frame: {slot3, slot2, slot1, slot0} led patterns
    logic [47:0] sb_q [$];

    task automatic check(input string name, input logic [11:0] got, input logic [11:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", name, got, exp, cyc);
        end else begin
            $display("ok   %s = %h (cycle %0d)", name, got, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge gclk);
        cyc += n;
    endtask

    task automatic goto_cyc(input int c);
        step(c - cyc);
    endtask

    task automatic write(input logic [15:0] d, input logic [3:0] p, input logic [3:0] b);
        data    = d;
        dp      = p;
        blank   = b;
        data_we = 1'b1;
        step(1);
        data_we = 1'b0;
    endtask

    task automatic push_frame(input logic [11:0] l0, input logic [11:0] l1,
                              input logic [11:0] l2, input logic [11:0] l3);
        sb_q.push_back({l3, l2, l1, l0});
    endtask

    // -------------------------------------------------------------------------
    // Monitor: at a frame pulse (cycle F) the next 64 cycles show the new
    // frame; the led in cycle F+j reflects slot (j-1)/16, cnt (j-1)%16.
    // -------------------------------------------------------------------------
    logic [47:0] mon_cur;
    bit          mon_active  = 1'b0;
    int          mon_j       = 0;
    int          frames_done = 0;

    always @(negedge gclk) begin
        int          s;
        int          c;
        logic [11:0] exp_led;
        if (mon_active) begin
            mon_j++;
            s       = (mon_j - 1) / 16;
            c       = (mon_j - 1) % 16;
            exp_led = mon_cur[s*12 +: 12];
            if (mon_j == 1) begin
                check($sformatf("f%0d_frame_width", frames_done), {11'd0, frame}, 12'd0);
            end
            if (c == 0 || c == 3) begin
                check($sformatf("f%0d_s%0d_c%0d_dead_anodes", frames_done, s, c),
                      {8'd0, led[11:8]}, 12'h00F);
            end
            if (c == 4 || c == 15) begin
                check($sformatf("f%0d_s%0d_c%0d_led", frames_done, s, c), led, exp_led);
            end
            if (mon_j == 64) begin
                mon_active = 1'b0;
                frames_done++;
            end
        end
        if (frame === 1'b1 && sb_q.size() > 0) begin
            mon_cur    = sb_q.pop_front();
            mon_active = 1'b1;
            mon_j      = 0;
        end
    end

    // -------------------------------------------------------------------------
    // Stimulus
    // -------------------------------------------------------------------------
    initial begin
        rst     = 1'b0;
        data    = 16'h0000;
        dp      = 4'h0;
        blank   = 4'h0;
        data_we = 1'b0;

        // Reset held three cycles with a write strobe that must be ignored
        @(negedge gclk);
        data = 16'hFFFF; dp = 4'hF; blank = 4'h0; data_we = 1'b1;
        repeat (3) begin
            @(negedge gclk);
            check("rst_led", led, 12'hFFF);
            check("rst_frame", {11'd0, frame}, 12'd0);
        end
        rst = 1'b1; data_we = 1'b0; cyc = 0;

        // Frame 0 shows the cleared display
        goto_cyc(4);  check("f0_s0_dead_anodes", {8'd0, led[11:8]}, 12'h00F);
        goto_cyc(5);  check("f0_s0_first_live", led, 12'hEC0);
        goto_cyc(16); check("f0_s0_last_live", led, 12'hEC0);

        // Basic write, invisible until the frame boundary
        goto_cyc(20);
        write(16'h1234, 4'h0, 4'h0);
        push_frame(12'hE99, 12'hDB0, 12'hBA4, 12'h7F9);
        goto_cyc(30); check("f0_s1_unchanged", led, 12'hDC0);
        goto_cyc(63); check("frame_before_boundary", {11'd0, frame}, 12'd0);
        goto_cyc(64); check("frame_pulse_c64", {11'd0, frame}, 12'd1);

        // Blank digit1, dp on digit0
        goto_cyc(80);
        write(16'h1234, 4'b0001, 4'b0010);
        push_frame(12'hE19, 12'hDFF, 12'hBA4, 12'h7F9);

        // Mid-frame write then a write in the boundary cycle itself
        goto_cyc(150);
        write(16'hAAAA, 4'h0, 4'h0);
        goto_cyc(191);
        write(16'h5555, 4'h0, 4'h0);
        push_frame(12'hE92, 12'hD92, 12'hB92, 12'h792);

        // Three writes in one frame: only the last one is shown next frame
        goto_cyc(200); write(16'h0F0F, 4'h0, 4'h0);
        goto_cyc(220); write(16'h89AB, 4'b1000, 4'h0);
        goto_cyc(240); write(16'hCDEF, 4'b0110, 4'h0);
        push_frame(12'hE8E, 12'hD06, 12'hB21, 12'h7C6);

        // Remaining hex codes, blank on digit3
        goto_cyc(270);
        write(16'h6789, 4'h0, 4'b1000);
        push_frame(12'hE90, 12'hD80, 12'hBF8, 12'h7FF);

        // Pending write, then reset during slot 2 with the strobe held high
        goto_cyc(390);
        write(16'h9999, 4'hF, 4'h0);
        goto_cyc(420);
        rst = 1'b0; data = 16'hFFFF; dp = 4'hF; blank = 4'h0; data_we = 1'b1;
        repeat (3) begin
            step(1);
            check("midrst_led", led, 12'hFFF);
            check("midrst_frame", {11'd0, frame}, 12'd0);
        end
        rst = 1'b1; data_we = 1'b0; cyc = 0;
        push_frame(12'hEC0, 12'hDC0, 12'hBC0, 12'h7C0);

        goto_cyc(10); check("post_rst_s0", led, 12'hEC0);
        goto_cyc(40); check("post_rst_s2", led, 12'hBC0);
        goto_cyc(63); check("post_rst_no_early_frame", {11'd0, frame}, 12'd0);
        goto_cyc(64); check("post_rst_frame_c64", {11'd0, frame}, 12'd1);

        goto_cyc(64 + 70);
        check("scoreboard_drained", 12'(sb_q.size()), 12'd0);
        check("frames_checked", 12'(frames_done), 12'd6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
